// File: rtl/rr_grant_scheduler_if.sv
// Request/grant bundle between N requesting masters and the round-robin
// scheduler.
//
// Protocol: a requester raises req[i] to ask for the shared resource and keeps
// it high for the whole time it needs the resource. grant[i] is the registered
// answer. A requester may use the resource only in cycles where grant[i] is
// high. Dropping req[i] releases the resource, and the grant falls after the
// next clock edge. No other handshake exists.
interface rr_grant_scheduler_if #(
  parameter int N = 4
);
  localparam int OW = $clog2(N);

  logic [N-1:0]  req;
  logic [N-1:0]  grant;
  logic [OW-1:0] owner;
  logic          busy;
  logic          timeout;
  logic          state_dbg;   // 0 = IDLE, 1 = HELD

  modport master (
    output req,
    input  grant, owner, busy, timeout, state_dbg
  );

  modport slave (
    input  req,
    output grant, owner, busy, timeout, state_dbg
  );
endinterface

// File: rtl/rr_grant_scheduler.sv
// Registered N-way round-robin scheduler with request/hold semantics.
// The search for the next owner starts one position after the previous owner.
// A non-owner request never preempts the current owner.
// Optional feature macro: RR_GRANT_TIMEOUT_EN. When it is defined, the design
// forces a tenure to end after MAX_HOLD grant cycles and pulses timeout.
module rr_grant_scheduler #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  rr_grant_scheduler_if.slave  bus
);

  localparam int OW = $clog2(N);

  if (N < 2 || N > 16) begin : g_bad_n
    $error("rr_grant_scheduler: N must be in 2..16");
  end
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
    $error("rr_grant_scheduler: MAX_HOLD must be in 1..255");
  end

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] last_q,  last_d;

  logic [N-1:0]  cand;
  logic          win_found;
  logic [OW-1:0] win_idx;
  logic [OW-1:0] pidx;
  int            pos;
  logic          release_own;
  logic          force_rel;

`ifdef RR_GRANT_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;
`endif

  // Rotating priority search: candidates are scanned from last+1 upward.
  // While HELD, the current owner is masked out. A released or timed-out owner
  // therefore cannot win on the edge that ends its own tenure.
  always_comb begin
    cand      = bus.req;
    win_found = 1'b0;
    win_idx   = '0;
    pos       = 0;
    pidx      = '0;
    if (state_q == ST_HELD) begin
      cand[owner_q] = 1'b0;
    end
    for (int off = 1; off <= N; off++) begin
      pos = int'(last_q) + off;
      if (pos >= N) begin
        pos = pos - N;
      end
      pidx = pos[OW-1:0];
      if (!win_found && cand[pidx]) begin
        win_found = 1'b1;
        win_idx   = pidx;
      end
    end
  end

  // Next-state logic: the grant is kept while the owner holds its request.
  // On release (or forced release) the grant passes directly to the winner,
  // or the block falls to IDLE.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    last_d      = last_q;
    release_own = 1'b0;
    force_rel   = 1'b0;
`ifdef RR_GRANT_TIMEOUT_EN
    cnt_d       = cnt_q;
    timeout_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d          = ST_HELD;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          owner_d          = win_idx;
          last_d           = win_idx;
`ifdef RR_GRANT_TIMEOUT_EN
          cnt_d            = 8'd0;
`endif
        end
      end
      ST_HELD: begin
        release_own = !bus.req[owner_q];
`ifdef RR_GRANT_TIMEOUT_EN
        // The count reaching the limit on this edge means the owner has had
        // MAX_HOLD visible grant cycles.
        force_rel   = !release_own && ((cnt_q + 8'd1) == HOLD_LIMIT);
        timeout_d   = force_rel;
`endif
        if (release_own || force_rel) begin
          if (win_found) begin
            grant_d          = '0;
            grant_d[win_idx] = 1'b1;
            owner_d          = win_idx;
            last_d           = win_idx;
`ifdef RR_GRANT_TIMEOUT_EN
            cnt_d            = 8'd0;
`endif
          end else begin
            state_d = ST_IDLE;
            grant_d = '0;
          end
        end else begin
`ifdef RR_GRANT_TIMEOUT_EN
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State registers. Reset drops any grant, and requester 0 becomes first in
  // line because last is set to N-1.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= OW'(N - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

`ifdef RR_GRANT_TIMEOUT_EN
  // Hold counter and the one-cycle timeout pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q     <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.grant     = grant_q;
  assign bus.owner     = owner_q;
  assign bus.busy      = (state_q == ST_HELD);
  assign bus.state_dbg = state_q;

endmodule
